// File: rtl/alu_pkg.sv
// Shared op-code constants and execute-unit FSM states for the ALU path.
// OP_MUL is decoded only in builds with MUL_EN defined.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_MUL = 4'b1001;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU ops (AND/OR/ADD/SUB) and the illegal op-code decode.
// With MUL_EN defined, OP_MUL is treated as a legal (iterative) op.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             illegal_op
);

    // Result is zero for iterative and illegal ops; the FSM supplies those results.
    always_comb begin
        result     = {WIDTH{1'b0}};
        illegal_op = 1'b0;
        case (operation)
            OP_AND:         result = operand_a & operand_b;
            OP_OR:          result = operand_a | operand_b;
            OP_ADD:         result = operand_a + operand_b;
            OP_SUB:         result = operand_a - operand_b;
            OP_SLL, OP_SRL: illegal_op = 1'b0;
`ifdef MUL_EN
            OP_MUL:         illegal_op = 1'b0;
`endif
            default: begin
                result     = {WIDTH{1'b0}};
                illegal_op = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes; shifts iterate one bit per cycle.
// Optional MUL_EN adds an iterative shift-add multiplier on op 1001.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal_op
);

    // One extra bit so the counter can hold WIDTH for the multiplier.
    localparam int CNT_W = SHAMT_W + 1;

    state_t             state_r, state_s;
    logic [3:0]         op_r, op_s;
    logic [WIDTH-1:0]   work_r, work_s, step_s;
    logic [WIDTH-1:0]   result_r, result_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               zero_r, zero_s, illegal_r, illegal_s;
    logic               in_ready_r, out_valid_r;
    logic [WIDTH-1:0]   core_res_s;
    logic               core_illegal_s;
    logic               accept_s;
`ifdef MUL_EN
    logic [WIDTH-1:0]   mb_r, mb_s, acc_r, acc_s;
`endif

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .operation  (operation),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .result     (core_res_s),
        .illegal_op (core_illegal_s)
    );

    assign accept_s   = in_valid && in_ready_r;
    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign result     = result_r;
    assign zero       = zero_r;
    assign illegal_op = illegal_r;

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_s   = state_r;
        op_s      = op_r;
        work_s    = work_r;
        step_s    = work_r;
        cnt_s     = cnt_r;
        result_s  = result_r;
        zero_s    = zero_r;
        illegal_s = illegal_r;
`ifdef MUL_EN
        mb_s      = mb_r;
        acc_s     = acc_r;
`endif
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    op_s      = operation;
                    illegal_s = core_illegal_s;
                    work_s    = operand_a;
                    cnt_s     = {1'b0, operand_b[SHAMT_W-1:0]};
                    if ((operation == OP_SLL) || (operation == OP_SRL)) begin
                        if (operand_b[SHAMT_W-1:0] == {SHAMT_W{1'b0}}) begin
                            result_s = operand_a;
                            zero_s   = (operand_a == {WIDTH{1'b0}});
                            state_s  = DONE;
                        end else begin
                            state_s  = SHIFT;
                        end
                    end
`ifdef MUL_EN
                    else if (operation == OP_MUL) begin
                        cnt_s   = CNT_W'(WIDTH);
                        mb_s    = operand_b;
                        acc_s   = {WIDTH{1'b0}};
                        state_s = SHIFT;
                    end
`endif
                    else begin
                        result_s = core_res_s;
                        zero_s   = (core_res_s == {WIDTH{1'b0}});
                        state_s  = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                cnt_s  = cnt_r - CNT_W'(1);
                work_s = (op_r == OP_SLL) ? {work_r[WIDTH-2:0], 1'b0}
                                          : {1'b0, work_r[WIDTH-1:1]};
                step_s = work_s;
`ifdef MUL_EN
                // Multiplicand moves left while the multiplier is consumed LSB first.
                if (op_r == OP_MUL) begin
                    work_s = {work_r[WIDTH-2:0], 1'b0};
                    mb_s   = {1'b0, mb_r[WIDTH-1:1]};
                    acc_s  = mb_r[0] ? (acc_r + work_r) : acc_r;
                    step_s = acc_s;
                end else begin
                    mb_s   = mb_r;
                    acc_s  = acc_r;
                end
`endif
                if (cnt_r == CNT_W'(1)) begin
                    result_s = step_s;
                    zero_s   = (step_s == {WIDTH{1'b0}});
                    state_s  = DONE;
                end else begin
                    state_s  = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            op_r        <= 4'b0000;
            work_r      <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            illegal_r   <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
`ifdef MUL_EN
            mb_r        <= {WIDTH{1'b0}};
            acc_r       <= {WIDTH{1'b0}};
`endif
        end else begin
            state_r     <= state_s;
            op_r        <= op_s;
            work_r      <= work_s;
            cnt_r       <= cnt_s;
            result_r    <= result_s;
            zero_r      <= zero_s;
            illegal_r   <= illegal_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
`ifdef MUL_EN
            mb_r        <= mb_s;
            acc_r       <= acc_s;
`endif
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table, random ops, backpressure and reset mid-op.
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int W = 64;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         zero;
        logic         ill;
        int           lat;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [3:0]   operation = 4'b0000;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         in_ready, out_valid, zero, illegal_op;
    logic [W-1:0] result;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    vec_t vecs[14];
    logic [3:0] rops[6] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLL, OP_SRL};

    alu_exec_unit #(.WIDTH(W), .SHAMT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operation  (operation),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] res, input logic z, input logic ill, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.zero = z; v.ill = ill; v.lat = lat;
        return v;
    endfunction

    // Behavioural reference for the random vectors.
    function automatic vec_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.ill = 1'b0; v.lat = 1;
        case (op)
            OP_AND: v.res = a & b;
            OP_OR:  v.res = a | b;
            OP_ADD: v.res = a + b;
            OP_SUB: v.res = a - b;
            OP_SLL: begin v.res = a << b[5:0]; v.lat = 1 + int'(b[5:0]); end
            OP_SRL: begin v.res = a >> b[5:0]; v.lat = 1 + int'(b[5:0]); end
            default: begin v.res = '0; v.ill = 1'b1; end
        endcase
        v.zero = (v.res == '0);
        return v;
    endfunction

    task automatic issue(input vec_t v);
        int g;
        operation = v.op; operand_a = v.a; operand_b = v.b; in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 200) begin step(); g++; end
        chk("in_ready_before_accept", W'(in_ready), W'(1));
        step();
        in_valid  = 1'b0;
        operation = 4'($urandom);
        operand_a = {$urandom, $urandom};
        operand_b = {$urandom, $urandom};
        exp_q.push_back('{v, cyc});
    endtask

    task automatic collect();
        int   g;
        int   lat;
        logic saw_ready;
        exp_t e;
        g = 0;
        saw_ready = 1'b0;
        while (!out_valid && g < 200) begin
            if (in_ready) saw_ready = 1'b1;
            step();
            g++;
        end
        chk("out_valid", W'(out_valid), W'(1));
        chk("sb_nonempty", W'(exp_q.size() != 0), W'(1));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            lat = cyc - e.acc_cyc + 1;
            chk("result", result, e.v.res);
            chk("zero", W'(zero), W'(e.v.zero));
            chk("illegal_op", W'(illegal_op), W'(e.v.ill));
            chk("busy_no_ready", W'(saw_ready), W'(0));
            if (e.v.lat >= 0) chk("latency", W'(lat), W'(e.v.lat));
        end
        out_ready = 1'b1;
        step();
        chk("out_valid_drop", W'(out_valid), W'(0));
        chk("in_ready_return", W'(in_ready), W'(1));
    endtask

    initial begin
        int n;
        vec_t v;

        repeat (3) step();
        chk("rst_result", result, W'(0));
        chk("rst_zero", W'(zero), W'(0));
        chk("rst_illegal", W'(illegal_op), W'(0));
        chk("rst_out_valid", W'(out_valid), W'(0));
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", W'(in_ready), W'(1));

        vecs[0]  = mk(OP_SUB, 64'd10, 64'd10, 64'd0, 1'b1, 1'b0, 1);
        vecs[1]  = mk(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1);
        vecs[2]  = mk(OP_OR, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0, 1);
        vecs[3]  = mk(OP_SLL, 64'd1, 64'd5, 64'd32, 1'b0, 1'b0, 6);
        vecs[4]  = mk(OP_SRL, 64'h80, 64'd0, 64'h80, 1'b0, 1'b0, 1);
        vecs[5]  = mk(4'b1111, 64'd7, 64'd9, 64'd0, 1'b1, 1'b1, 1);
`ifdef MUL_EN
        vecs[6]  = mk(OP_MUL, 64'd3, 64'd7, 64'd21, 1'b0, 1'b0, 65);
`else
        vecs[6]  = mk(OP_MUL, 64'd3, 64'd7, 64'd0, 1'b1, 1'b1, 1);
`endif
        vecs[7]  = mk(OP_AND, 64'd12, 64'd10, 64'd8, 1'b0, 1'b0, 1);
        vecs[8]  = mk(OP_SRL, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b0, 1'b0, 64);
        vecs[9]  = mk(OP_SLL, 64'hF, 64'd68, 64'hF0, 1'b0, 1'b0, 5);
        vecs[10] = mk(OP_SUB, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1);
        vecs[11] = mk(4'b0101, 64'd5, 64'd5, 64'd0, 1'b1, 1'b1, 1);
        vecs[12] = mk(OP_SLL, 64'd3, 64'd63, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64);
        vecs[13] = mk(OP_SRL, 64'hF, 64'd4, 64'd0, 1'b1, 1'b0, 5);

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i]);
            collect();
        end

        for (int i = 0; i < 8; i++) begin
            n = $urandom_range(0, 5);
            v = model(rops[n], {$urandom, $urandom}, {$urandom, $urandom});
            issue(v);
            collect();
        end

        // Backpressure: result held while in_valid keeps presenting other ops.
        out_ready = 1'b0;
        issue(mk(OP_AND, 64'd12, 64'd10, 64'd8, 1'b0, 1'b0, -1));
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            operation = OP_SUB; operand_a = 64'(i + 100); operand_b = 64'd1;
            step();
            chk("bp_out_valid", W'(out_valid), W'(1));
            chk("bp_result", result, W'(8));
            chk("bp_in_ready", W'(in_ready), W'(0));
        end
        operation = OP_ADD; operand_a = 64'd1; operand_b = 64'd1;
        collect();
        step();
        in_valid = 1'b0;
        exp_q.push_back('{mk(OP_ADD, 64'd1, 64'd1, 64'd2, 1'b0, 1'b0, 1), cyc});
        collect();

        // Reset during the third cycle of a 10-bit shift.
        issue(mk(OP_SLL, 64'd1, 64'd10, 64'd1024, 1'b0, 1'b0, 11));
        step();
        step();
        rst_n = 1'b0;
        step();
        exp_q.delete();
        chk("rstmid_out_valid", W'(out_valid), W'(0));
        chk("rstmid_in_ready", W'(in_ready), W'(1));
        chk("rstmid_result", result, W'(0));
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) n++;
        end
        chk("rstmid_no_emit", W'(n), W'(0));
        issue(mk(OP_ADD, 64'd2, 64'd3, 64'd5, 1'b0, 1'b0, 1));
        collect();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage consumer of the 4-bit ALU operation code produced by ALU control. Also takes the two register/immediate operands.
- Logic ops and add/sub complete in one cycle. Shifts iterate one bit per cycle, so no barrel shifter is needed.
- Valid/ready handshakes on input and output let the datapath stall on multi-cycle ops.
- The zero flag feeds branch (beq) resolution.

Parameters:
- WIDTH, 64, operand and result width in bits.
- SHAMT_W, 6, shift-amount bits taken from operand_b; must equal clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operation/operands valid
- in_ready  output  1  unit can accept an operation
- operation  input  4  op code from ALU control
- operand_a  input  WIDTH  first operand
- operand_b  input  WIDTH  second operand; low SHAMT_W bits are the shift amount for shifts
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- zero  output  1  result == 0
- illegal_op  output  1  op code unsupported

Behaviour:
- Reset:
  - Sampled on clk edge when rst_n=0.
  - state=IDLE; result=0, zero=0, illegal_op=0, out_valid=0.
  - in_ready reads 1 on the cycle after reset deasserts.
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (a-b).
  - 0011 SLL, 0100 SRL (logical, zero fill).
  - All others illegal.
- Arithmetic: modulo 2^WIDTH; carry and overflow are discarded.
- FSM IDLE:
  - in_ready=1, out_valid=0.
  - Accept when in_valid&&in_ready, latching op, a, and b.
  - Single-cycle op or illegal op: compute and go to DONE.
  - Shift: load a into the working register and shamt into the counter.
    - shamt==0 goes to DONE with result=a.
    - Otherwise go to SHIFT.
- FSM SHIFT:
  - Each cycle shift the working register 1 bit and decrement the counter.
  - When the counter reaches 1, the final shift is written and the FSM goes to DONE.
  - in_ready=0.
- FSM DONE:
  - out_valid=1; result, zero and illegal_op are held stable until out_ready=1.
  - On out_valid&&out_ready, go to IDLE.
  - No new op is accepted in DONE (in_ready=0). Throughput is one op per latency+1 cycles.
- Latency (accept edge N to out_valid high):
  - Single-cycle and illegal ops: N+1.
  - Shift by k>0: N+1+k.
- Illegal op: result=0, zero=1, illegal_op=1, latency 1.
- illegal_op is cleared on the next accepted legal op.
- Inputs are ignored when in_ready=0; operands may change freely after acceptance.
- Backpressure: out_ready may stay low indefinitely, and outputs must not change while it does.
- Reset mid-op: an in-flight shift is aborted, any held result is discarded and out_valid drops at the reset edge.

Optional Feature:
- Macro MUL_EN.
- Defined:
  - Op 1001 is MUL, giving the low WIDTH bits of a*b.
  - Uses a shift-add iterative multiplier that reuses the SHIFT state counter. The counter is loaded with WIDTH and consumes one bit of b per cycle.
  - Latency WIDTH+1 cycles.
- Undefined: 1001 is illegal (illegal_op=1, result=0), and no multiplier logic is synthesized.

Decomposition:
- Shared package alu_pkg:
  - OP_AND=4'b0000, OP_OR=4'b0001, OP_ADD=4'b0010, OP_SLL=4'b0011, OP_SRL=4'b0100, OP_SUB=4'b0110, OP_MUL=4'b1001.
  - FSM state typedef {IDLE, SHIFT, DONE}.
- ALU control imports the same op constants.
- One sub-module, alu_comb_core: purely combinational AND/OR/ADD/SUB plus the illegal-op decode. The sequential FSM, shifter and counter stay in alu_exec_unit.

Test Plan:
- Reset then SUB with a=10, b=10, out_ready=1 -> out_valid on cycle N+1, result=0, zero=1, illegal_op=0; in_ready returns high the cycle after.
- ADD with a=64'hFFFF_FFFF_FFFF_FFFF, b=1 -> result=0, zero=1 (wrap). Then OR with a=8'hF0, b=8'h0F -> result=8'hFF, zero=0.
- SLL with a=1, b=5 -> in_ready low for 5 cycles, out_valid at N+6, result=32. SRL with a=64'h80, b=0 -> out_valid at N+1, result=64'h80.
- AND with a=12, b=10, out_ready held 0 for 4 cycles while in_valid stays high with new values -> result=8 stable, no second accept until the out handshake completes.
- Op 4'b1111 -> result=0, zero=1, illegal_op=1. Op 1001 with a=3, b=7 -> with MUL_EN: result=21 at N+65; without MUL_EN: illegal_op=1.
- rst_n=0 during the 3rd cycle of SLL by 10 -> state IDLE and out_valid=0 next cycle, no result emitted; a following ADD with a=2, b=3 gives result=5.
